// File: rtl/rob.sv
// Reorder buffer: allocates REG/BRANCH/STORE entries, collects results, commits in order, flushes on mispredict.
// Optional macro ROB_BYPASS_EN: operand lookups also see same-cycle rs/lsb broadcasts.
module rob #(
    parameter  int ROB_SIZE = 16,
    localparam int ID_W     = $clog2(ROB_SIZE),
    localparam int CNT_W    = ID_W + 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            dc_valid,
    input  logic [1:0]      dc_type,
    input  logic [4:0]      dc_rd,
    input  logic            dc_pred_taken,
    input  logic [31:0]     dc_alt_pc,
    output logic [ID_W-1:0] rob_tail_id,
    output logic            rob_full,
    input  logic            rs_has_output,
    input  logic [ID_W-1:0] rs_rob_id,
    input  logic [31:0]     rs_output,
    input  logic            is_lsb,
    input  logic [ID_W-1:0] lsb_rob_id,
    input  logic [31:0]     lsb_res,
    input  logic [ID_W-1:0] q1_id,
    input  logic [ID_W-1:0] q2_id,
    output logic            q1_ready,
    output logic            q2_ready,
    output logic [31:0]     q1_value,
    output logic [31:0]     q2_value,
    output logic            cm_valid,
    output logic [4:0]      cm_rd,
    output logic [ID_W-1:0] cm_rob_id,
    output logic [31:0]     cm_value,
    output logic            st_commit,
    output logic [ID_W-1:0] st_rob_id,
    output logic            rob_clear,
    output logic [31:0]     rob_clear_pc
);

    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;

    logic        busy_q  [ROB_SIZE], busy_d  [ROB_SIZE];
    logic        ready_q [ROB_SIZE], ready_d [ROB_SIZE];
    logic [1:0]  type_q  [ROB_SIZE], type_d  [ROB_SIZE];
    logic [4:0]  rd_q    [ROB_SIZE], rd_d    [ROB_SIZE];
    logic        pred_q  [ROB_SIZE], pred_d  [ROB_SIZE];
    logic [31:0] alt_q   [ROB_SIZE], alt_d   [ROB_SIZE];
    logic [31:0] value_q [ROB_SIZE], value_d [ROB_SIZE];

    logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic            cm_valid_q, cm_valid_d, st_commit_q, st_commit_d, rob_clear_q, rob_clear_d;
    logic [4:0]      cm_rd_q, cm_rd_d;
    logic [ID_W-1:0] cm_rob_id_q, cm_rob_id_d, st_rob_id_q, st_rob_id_d;
    logic [31:0]     cm_value_q, cm_value_d, rob_clear_pc_q, rob_clear_pc_d;

    logic active, do_alloc, do_commit, mispredict;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(ROB_SIZE - 1)) ? '0 : id + 1'b1;
    endfunction

    // The cycle showing rob_clear is the tail of a flush: nothing may enter or leave.
    always_comb begin
        active     = rdy_in && !rob_clear_q;
        do_alloc   = active && dc_valid && (count_q < CNT_W'(ROB_SIZE));
        do_commit  = active && (count_q != '0) && ready_q[head_q];
        mispredict = do_commit && (type_q[head_q] == TYPE_BRANCH)
                     && (value_q[head_q][0] != pred_q[head_q]);
    end

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            busy_d[i]  = busy_q[i];
            ready_d[i] = ready_q[i];
            type_d[i]  = type_q[i];
            rd_d[i]    = rd_q[i];
            pred_d[i]  = pred_q[i];
            alt_d[i]   = alt_q[i];
            value_d[i] = value_q[i];
            if (active && busy_q[i] && !ready_q[i]) begin
                if (rs_has_output && rs_rob_id == ID_W'(i)) begin
                    ready_d[i] = 1'b1;
                    value_d[i] = rs_output;
                end else if (is_lsb && lsb_rob_id == ID_W'(i)) begin
                    ready_d[i] = 1'b1;
                    value_d[i] = lsb_res;
                end
            end
            if (do_alloc && tail_q == ID_W'(i)) begin
                busy_d[i]  = 1'b1;
                ready_d[i] = (dc_type == TYPE_STORE);
                type_d[i]  = dc_type;
                rd_d[i]    = dc_rd;
                pred_d[i]  = dc_pred_taken;
                alt_d[i]   = dc_alt_pc;
                value_d[i] = '0;
            end
            if ((do_commit && head_q == ID_W'(i)) || mispredict) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        head_d  = do_commit ? next_id(head_q) : head_q;
        tail_d  = do_alloc ? next_id(tail_q) : tail_q;
        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pulse flops freeze with the rest of the state while rdy_in is low; outputs are gated below.
    always_comb begin
        cm_valid_d     = cm_valid_q;
        cm_rd_d        = cm_rd_q;
        cm_rob_id_d    = cm_rob_id_q;
        cm_value_d     = cm_value_q;
        st_commit_d    = st_commit_q;
        st_rob_id_d    = st_rob_id_q;
        rob_clear_d    = rob_clear_q;
        rob_clear_pc_d = rob_clear_pc_q;
        if (rdy_in) begin
            cm_valid_d  = 1'b0;
            st_commit_d = 1'b0;
            rob_clear_d = 1'b0;
            if (do_commit) begin
                if (type_q[head_q] == TYPE_STORE) begin
                    st_commit_d = 1'b1;
                    st_rob_id_d = head_q;
                end else if (type_q[head_q] == TYPE_BRANCH) begin
                    if (mispredict) begin
                        rob_clear_d    = 1'b1;
                        rob_clear_pc_d = alt_q[head_q];
                    end
                end else begin
                    cm_valid_d  = 1'b1;
                    cm_rd_d     = rd_q[head_q];
                    cm_rob_id_d = head_q;
                    cm_value_d  = value_q[head_q];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q         <= '{default: 1'b0};
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            cm_valid_q     <= 1'b0;
            cm_rd_q        <= '0;
            cm_rob_id_q    <= '0;
            cm_value_q     <= '0;
            st_commit_q    <= 1'b0;
            st_rob_id_q    <= '0;
            rob_clear_q    <= 1'b0;
            rob_clear_pc_q <= '0;
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            pred_q         <= pred_d;
            alt_q          <= alt_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cm_valid_q     <= cm_valid_d;
            cm_rd_q        <= cm_rd_d;
            cm_rob_id_q    <= cm_rob_id_d;
            cm_value_q     <= cm_value_d;
            st_commit_q    <= st_commit_d;
            st_rob_id_q    <= st_rob_id_d;
            rob_clear_q    <= rob_clear_d;
            rob_clear_pc_q <= rob_clear_pc_d;
        end
    end

    function automatic logic [32:0] lookup(input logic [ID_W-1:0] id);
        logic [32:0] res;
        res = '0;
        if (busy_q[id] && ready_q[id]) begin
            res = {1'b1, value_q[id]};
        end
`ifdef ROB_BYPASS_EN
        else if (active && busy_q[id] && rs_has_output && rs_rob_id == id) begin
            res = {1'b1, rs_output};
        end else if (active && busy_q[id] && is_lsb && lsb_rob_id == id) begin
            res = {1'b1, lsb_res};
        end
`endif
        return res;
    endfunction

    always_comb begin
        {q1_ready, q1_value} = lookup(q1_id);
        {q2_ready, q2_value} = lookup(q2_id);
    end

    assign rob_tail_id  = tail_q;
    assign rob_full     = (count_q >= CNT_W'(ROB_SIZE - 1));
    assign cm_valid     = cm_valid_q && rdy_in;
    assign cm_rd        = cm_rd_q;
    assign cm_rob_id    = cm_rob_id_q;
    assign cm_value     = cm_value_q;
    assign st_commit    = st_commit_q && rdy_in;
    assign st_rob_id    = st_rob_id_q;
    assign rob_clear    = rob_clear_q && rdy_in;
    assign rob_clear_pc = rob_clear_pc_q;

endmodule
